uart_rx: RTL and testbench

Serial UART receiver: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous `rx_i` line and presents each byte to the CPU-side peripheral bus. It is the receive half of the console UART and runs at the same `CLK_FREQ`/`BAUD_RATE` as the transmitter. Sampling uses a mid-bit counter derived from the bit period, with a synchronizer and false-start rejection.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud-timing helpers.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  function automatic int unsigned uart_bit_period(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned uart_half_period(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
    return uart_bit_period(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO succeeds only if a pop
// happens in the same cycle, otherwise the byte is dropped and o_drop is raised.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Head is masked while empty so data_o reads 0 out of reset.
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid = !w_empty;
  assign o_drop  = i_push && !w_push;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and false-start rejection.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH-entry FWFT FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_i,
  input  logic                   ready_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   valid_o,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   busy_o
);

  localparam int unsigned BIT_PERIOD = uart_bit_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF       = uart_half_period(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BP_LAST    = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF - 1);

  if (BIT_PERIOD < 4 || BIT_PERIOD > 65535) begin : g_bad_period
    $error("uart_rx: BIT_PERIOD must be within 4..65535");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [1:0]             r_sync;
  logic                   w_rx_s;
  uart_state_e            r_state, w_next;
  logic [15:0]            r_cnt;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_frame_err;
  logic                   w_tick, w_sample, w_deliver, w_ferr, w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx_i};
  end
  assign w_rx_s = r_sync[1];

  // START waits half a bit to land mid start-bit; later bits are a full period apart.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      START:      w_tick = (r_cnt == HALF_LAST);
      DATA, STOP: w_tick = (r_cnt == BP_LAST);
      default:    w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_rx_s) w_next = START;
      START:     if (w_tick) w_next = w_rx_s ? IDLE : DATA;
      DATA:      if (w_tick && r_bit_idx == 3'd7) w_next = STOP;
      STOP:      if (w_tick) w_next = w_rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (w_rx_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != IDLE);
    w_sample  = (r_state == DATA) && w_tick;
    w_deliver = (r_state == STOP) && w_tick && w_rx_s;
    w_ferr    = (r_state == STOP) && w_tick && !w_rx_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (r_state == IDLE || r_state == WAIT_IDLE || w_tick) r_cnt <= '0;
      else                                                   r_cnt <= r_cnt + 16'd1;
      if (r_state != DATA) r_bit_idx <= '0;
      else if (w_tick)     r_bit_idx <= r_bit_idx + 3'd1;
      if (w_sample) r_shift <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
      r_frame_err <= w_ferr;
    end
  end

  assign frame_err_o = r_frame_err;
  assign busy_o      = w_busy;

`ifdef UART_RX_FIFO_EN
  logic w_drop, r_overrun;

  uart_rx_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_deliver),
    .i_data  (r_shift),
    .i_pop   (ready_i),
    .o_data  (data_o),
    .o_valid (valid_o),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overrun <= 1'b0;
    else        r_overrun <= w_drop;
  end
  assign overrun_o = r_overrun;
`else
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;
  logic                   w_unused_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_deliver;
      if (w_deliver) r_data <= r_shift;
    end
  end

  assign w_unused_ready = ready_i;
  assign data_o         = r_data;
  assign valid_o        = r_valid;
  assign overrun_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are built from bit lists and the
// received byte stream is compared against the queue of bytes sent with a good stop bit.
module tb_uart_rx;

  localparam int CLK_FREQ   = 1000000;
  localparam int BAUD_RATE  = 100000;
  localparam int BP         = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BP / 2;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_ferr = 0, n_ovr = 0, n_vwide = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic [7:0] exp_q[$];
  int         got_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect delivered bytes and count pulses, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef UART_RX_FIFO_EN
      if (valid_o && ready_i) begin
        got_q.push_back(data_o);
        got_cyc_q.push_back(cyc);
      end
`else
      if (valid_o) begin
        got_q.push_back(data_o);
        got_cyc_q.push_back(cyc);
      end
      if (valid_o && prev_valid) n_vwide <= n_vwide + 1;
`endif
      if (frame_err_o) n_ferr <= n_ferr + 1;
      if (overrun_o)   n_ovr  <= n_ovr + 1;
      prev_valid <= valid_o;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; each bit is held for exactly one bit period.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic bits[10];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = stop_bit;
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      repeat (BP) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_rd + i < got_q.size())
        check({tag, "_data"}, 32'(got_q[got_rd + i]), 32'(exp_q[i]));
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int t0, lat, base_ferr, base_ovr;
    logic [7:0] b;
    logic [7:0] msg[3];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with latency check
    base_ferr = n_ferr;
    t0 = cyc;
    send_byte(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    repeat (4) @(negedge clk);
    wait_idle("b55");
    lat = (got_cyc_q.size() > got_rd) ? got_cyc_q[got_rd] - t0 : -1;
    check("latency_ok", 32'(lat >= 2 + HALF + 9*BP && lat <= 4 + HALF + 9*BP), 32'd1);
    compare_q("b55");
    check("b55_ferr", 32'(n_ferr - base_ferr), 32'd0);

    // Glitch shorter than half a bit is rejected
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy", 32'(busy_o), 32'd0);
    repeat (20) @(negedge clk);
    compare_q("glitch");

    // Framing error, break, then a good byte
    base_ferr = n_ferr;
    send_byte(8'hA5, 1'b0);
    rx_i = 1'b0;
    repeat (30) @(negedge clk);
    check("break_busy", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("break_release", 32'(busy_o), 32'd0);
    send_byte(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    repeat (4) @(negedge clk);
    wait_idle("ferr");
    check("ferr_pulses", 32'(n_ferr - base_ferr), 32'd1);
    compare_q("ferr");

    // Back-to-back frames, no idle gap
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      send_byte(msg[i], 1'b1);
      exp_q.push_back(msg[i]);
    end
    repeat (4) @(negedge clk);
    wait_idle("b2b");
    compare_q("b2b");

    // Reset in the middle of a frame
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_data", 32'(data_o), 32'h0);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_ferr", 32'(frame_err_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    send_byte(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    repeat (4) @(negedge clk);
    wait_idle("rst");
    compare_q("rst");

    // Random bytes with random idle gaps (including none)
    base_ferr = n_ferr;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      exp_q.push_back(b);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    wait_idle("rand");
    compare_q("rand");
    check("rand_ferr", 32'(n_ferr - base_ferr), 32'd0);

`ifdef UART_RX_FIFO_EN
    // Fill past capacity, then drain
    base_ovr = n_ovr;
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (5) @(negedge clk);
    check("fifo_ovr", 32'(n_ovr - base_ovr), 32'd1);
    check("fifo_valid_full", 32'(valid_o), 32'd1);
    check("fifo_head", 32'(data_o), 32'h01);
    ready_i = 1'b1;
    repeat (8) @(negedge clk);
    check("fifo_valid_empty", 32'(valid_o), 32'd0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    compare_q("fifo");
`else
    base_ovr = 0;
    check("no_ovr", 32'(n_ovr - base_ovr), 32'd0);
    check("valid_pulse_width", 32'(n_vwide), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
